pipe_stage_buf: RTL and testbench
=================================

# pipe_stage_buf

Parametrised pipeline stage register with a two-entry skid buffer, valid/ready handshake, stall-vector hold and synchronous flush. It replaces the fixed-width inter-stage registers between adjacent CPU pipeline stages (e.g. execute→memory). Control and data payloads are set by parameters. A stage held by the stall vector emits a true bubble: valid low and control bits zero. A saturating counter records bubble cycles for performance analysis.

## Interface
- CTRL_W, 12: width of control payload (write enables, mem control); forced to zero whenever output is not valid
- DATA_W, 69: width of data payload (operands, destination register)
- STALL_W, 6: width of the pipeline stall vector
- STAGE, 3: index of the stall bit that holds this stage; 0 ≤ STAGE < STALL_W
- CNT_W, 16: width of bubble counter
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-low (0 = in reset)
- stall  input  STALL_W  pipeline stall vector; only bit STAGE used
- flush  input  1  synchronous discard of all buffered entries
- in_valid  input  1  upstream presents an entry
- in_ready  output  1  stage accepts the entry this cycle
- in_ctrl  input  CTRL_W  upstream control payload
- in_data  input  DATA_W  upstream data payload
- out_valid  output  1  head entry presented downstream
- out_ready  input  1  downstream consumes head this cycle
- out_ctrl  output  CTRL_W  head control, zero when out_valid=0
- out_data  output  DATA_W  head data, zero when out_valid=0
- occupancy  output  2  entries held (0..2)
- bubble_cnt  output  CNT_W  saturating count of hold cycles

## Operation
- Storage: two slots; 1-bit write pointer, 1-bit read pointer, 2-bit count.
- hold = stall[STAGE].
- in_ready = reset && (count != 2) && !hold && !flush. It never depends on out_ready.
- out_valid = reset && (count != 0) && !hold && !flush.
- push = in_valid && in_ready: the slot at the write pointer is loaded, then the write pointer toggles.
- pop = out_valid && out_ready: the read pointer toggles.
- count' = count + push − pop. Push and pop in the same cycle at count 1 leave count at 1 with both pointers toggled. At count 0 a pop is impossible; at count 2 a push is impossible.
- flush (edge-sampled): count, write pointer and read pointer all return to 0. Flush overrides any push or pop in that cycle. Slot contents are don't-care after a flush.
- hold: no push and no pop; contents and pointers are unchanged. Downstream sees a bubble (out_valid=0, out_ctrl=0, out_data=0).
- bubble_cnt increments on every edge where hold=1 and flush=0. It saturates at all-ones and is cleared only by reset.
- Entries leave in strict FIFO order. No entry is duplicated or dropped except by flush.

## Timing
- Reset is asynchronous: count, pointers, slots and bubble_cnt go to 0 immediately on reset=0. While reset=0: in_ready=0, out_valid=0, out_ctrl=0, out_data=0, occupancy=0. The first push is possible on the first edge after reset=1.
- Latency: an entry pushed at edge N is presented on out_* from just after edge N. Minimum latency is 1 cycle; with full throughput there is 1 entry per cycle.
- The second slot absorbs one extra entry when out_ready drops, so upstream sees in_ready fall one cycle later (skid). in_ready returns to 1 the cycle after the first pop from full.
- hold and flush act combinationally on in_ready and out_valid in the same cycle, and on state at the next edge.
- Reset asserted mid-transfer discards everything; there is no partial state.
- Simultaneous flush and hold: flush wins for state, and bubble_cnt does not increment.

## Test plan
- Reset: drive reset=0 mid-cycle with count=2 → outputs zero immediately. Release reset, push ctrl=0x0A5 data=0x1 → out_valid=1, out_ctrl=0x0A5 one edge later.
- Streaming: out_ready=1, push 0x1..0x8 on consecutive cycles → same order out, 1 per cycle, occupancy stays 1.
- Skid: push 0x10, 0x11, 0x12 with out_ready=0 from the second cycle → occupancy 2, in_ready=0, 0x12 stalls upstream. Raise out_ready → 0x10, 0x11, then 0x12 delivered in order.
- Hold bubble: occupancy 1, stall=6'b001000 for 3 cycles → out_valid=0, out_ctrl=0 throughout, bubble_cnt +3. Entry is presented again unchanged afterwards.
- Flush: occupancy 2, flush=1 with in_valid=1 → next cycle occupancy=0, input entry not accepted, out_valid=0.
- Saturation: CNT_W=4, hold for 20 cycles → bubble_cnt=15 and stays there.

Source files
------------

// File: rtl/pipe_stage_buf_if.sv
// Valid/ready stream bundle carrying one pipeline entry (control + data).
// The master drives valid/ctrl/data and samples ready; the slave does the reverse.
//   valid : entry presented this cycle
//   ready : receiver consumes the entry this cycle
//   ctrl  : control payload (write enables, memory control)
//   data  : data payload (operands, destination register)
interface pipe_stage_buf_if #(
  parameter int CTRL_W = 12,
  parameter int DATA_W = 69
);
  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (output valid, output ctrl, output data, input ready);
  modport slave  (input valid, input ctrl, input data, output ready);
endinterface

// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with a two-entry skid buffer, valid/ready handshake,
// stall-vector hold, synchronous flush and a saturating bubble counter.
// Ports:
//   clk        : clock, all state on rising edge
//   reset      : asynchronous active-low reset
//   stall      : pipeline stall vector, only bit STAGE holds this stage
//   flush      : synchronous discard of all buffered entries
//   up         : upstream stream (slave side: valid/ctrl/data in, ready out)
//   dn         : downstream stream (master side: valid/ctrl/data out, ready in)
//   occupancy  : number of entries held (0..2)
//   bubble_cnt : saturating count of hold cycles, cleared only by reset
module pipe_stage_buf #(
  parameter int CTRL_W  = 12,
  parameter int DATA_W  = 69,
  parameter int STALL_W = 6,
  parameter int STAGE   = 3,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  pipe_stage_buf_if.slave    up,
  pipe_stage_buf_if.master   dn,
  output logic [1:0]         occupancy,
  output logic [CNT_W-1:0]   bubble_cnt
);

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic [CTRL_W-1:0] ctrl_mem_r [2];
  logic [DATA_W-1:0] data_mem_r [2];
  logic              wr_ptr_r;
  logic              rd_ptr_r;
  logic [1:0]        count_r;
  logic [1:0]        count_nxt_s;
  logic [CNT_W-1:0]  bubble_cnt_r;
  logic              hold_s;
  logic              in_ready_s;
  logic              out_valid_s;
  logic              push_s;
  logic              pop_s;

  assign hold_s = stall[STAGE];

  // in_ready deliberately ignores out_ready: the second slot is the skid
  // space, so upstream only stalls once both slots are occupied.
  assign in_ready_s  = reset && (count_r != 2'd2) && !hold_s && !flush;
  assign out_valid_s = reset && (count_r != 2'd0) && !hold_s && !flush;
  assign push_s      = up.valid && in_ready_s;
  assign pop_s       = out_valid_s && dn.ready;

  // Next occupancy: push and pop together leave the count unchanged.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + 2'd1;
      2'b01:   count_nxt_s = count_r - 2'd1;
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointer and occupancy state; flush overrides any push or pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else if (flush) begin
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      wr_ptr_r <= push_s ? ~wr_ptr_r : wr_ptr_r;
      rd_ptr_r <= pop_s  ? ~rd_ptr_r : rd_ptr_r;
      count_r  <= count_nxt_s;
    end
  end

  // Slot storage; push already excludes flush and hold through in_ready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_mem_r[0] <= {CTRL_W{1'b0}};
      ctrl_mem_r[1] <= {CTRL_W{1'b0}};
      data_mem_r[0] <= {DATA_W{1'b0}};
      data_mem_r[1] <= {DATA_W{1'b0}};
    end else if (push_s) begin
      ctrl_mem_r[wr_ptr_r] <= up.ctrl;
      data_mem_r[wr_ptr_r] <= up.data;
    end else begin
      ctrl_mem_r[wr_ptr_r] <= ctrl_mem_r[wr_ptr_r];
      data_mem_r[wr_ptr_r] <= data_mem_r[wr_ptr_r];
    end
  end

  // Bubble counter: counts held edges, but a flush in the same cycle wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bubble_cnt_r <= {CNT_W{1'b0}};
    end else if (hold_s && !flush) begin
      bubble_cnt_r <= sat_inc(bubble_cnt_r);
    end else begin
      bubble_cnt_r <= bubble_cnt_r;
    end
  end

  // A non-valid head is a true bubble: payload forced to zero.
  assign up.ready   = in_ready_s;
  assign dn.valid   = out_valid_s;
  assign dn.ctrl    = out_valid_s ? ctrl_mem_r[rd_ptr_r] : {CTRL_W{1'b0}};
  assign dn.data    = out_valid_s ? data_mem_r[rd_ptr_r] : {DATA_W{1'b0}};
  assign occupancy  = count_r;
  assign bubble_cnt = bubble_cnt_r;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf: directed scenarios plus a randomized
// run, all checked against a queue-based reference model of the buffer.
module tb_pipe_stage_buf;
  localparam int CTRL_W  = 12;
  localparam int DATA_W  = 69;
  localparam int STALL_W = 6;
  localparam int STAGE   = 3;
  localparam int CNT_W   = 16;
  localparam int PW      = CTRL_W + DATA_W;

  logic               clk = 1'b0;
  logic               reset;
  logic [STALL_W-1:0] stall;
  logic               flush;
  logic [1:0]         occupancy;
  logic [CNT_W-1:0]   bubble_cnt;
  logic [STALL_W-1:0] stall2;
  logic               flush2;
  logic [1:0]         occupancy2;
  logic [3:0]         bubble_cnt2;

  pipe_stage_buf_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) up_if ();
  pipe_stage_buf_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) dn_if ();
  pipe_stage_buf_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) up2_if ();
  pipe_stage_buf_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) dn2_if ();

  pipe_stage_buf #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .STALL_W(STALL_W),
                   .STAGE(STAGE), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .up(up_if), .dn(dn_if), .occupancy(occupancy), .bubble_cnt(bubble_cnt));

  pipe_stage_buf #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .STALL_W(STALL_W),
                   .STAGE(STAGE), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .stall(stall2), .flush(flush2),
    .up(up2_if), .dn(dn2_if), .occupancy(occupancy2), .bubble_cnt(bubble_cnt2));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: FIFO of {ctrl,data} entries and a bubble tally.
  logic [PW-1:0] q[$];
  int            mb = 0;

  function automatic logic m_in_ready();
    return reset && (q.size() < 2) && !stall[STAGE] && !flush;
  endfunction

  function automatic logic m_out_valid();
    return reset && (q.size() != 0) && !stall[STAGE] && !flush;
  endfunction

  function automatic logic [CTRL_W-1:0] m_ctrl();
    logic [PW-1:0] h;
    h = (q.size() != 0) ? q[0] : '0;
    return m_out_valid() ? h[PW-1:DATA_W] : '0;
  endfunction

  function automatic logic [DATA_W-1:0] m_data();
    logic [PW-1:0] h;
    h = (q.size() != 0) ? q[0] : '0;
    return m_out_valid() ? h[DATA_W-1:0] : '0;
  endfunction

  task automatic drive(input logic v, input logic [CTRL_W-1:0] c,
                       input logic [DATA_W-1:0] d, input logic r);
    up_if.valid = v;
    up_if.ctrl  = c;
    up_if.data  = d;
    dn_if.ready = r;
  endtask

  // Advance one clock edge and apply the same edge to the model.
  task automatic tick();
    logic pu;
    logic po;
    logic hb;
    pu = up_if.valid && m_in_ready();
    po = m_out_valid() && dn_if.ready;
    hb = reset && stall[STAGE] && !flush;
    @(posedge clk);
    if (!reset) begin
      q.delete();
      mb = 0;
    end else if (flush) begin
      q.delete();
    end else begin
      if (po) void'(q.pop_front());
      if (pu) q.push_back({up_if.ctrl, up_if.data});
    end
    if (hb && mb < 65535) mb++;
    #1;
  endtask

  task automatic test_reset();
    #1;
    n_cmp += 6;
    if (up_if.ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b want 0", up_if.ready); end
    if (dn_if.valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", dn_if.valid); end
    if (dn_if.ctrl !== '0) begin n_err++; $display("FAIL rst_out_ctrl: got %h want 0", dn_if.ctrl); end
    if (dn_if.data !== '0) begin n_err++; $display("FAIL rst_out_data: got %h want 0", dn_if.data); end
    if (occupancy !== 2'd0) begin n_err++; $display("FAIL rst_occupancy: got %0d want 0", occupancy); end
    if (bubble_cnt !== '0) begin n_err++; $display("FAIL rst_bubble: got %0d want 0", bubble_cnt); end
    reset = 1'b1;
    drive(1'b1, 12'h001, 69'h1, 1'b0);
    tick();
    drive(1'b1, 12'h002, 69'h2, 1'b0);
    tick();
    #1;
    n_cmp += 2;
    if (occupancy !== 2'd2) begin n_err++; $display("FAIL full_occupancy: got %0d want 2", occupancy); end
    if (up_if.ready !== 1'b0) begin n_err++; $display("FAIL full_in_ready: got %b want 0", up_if.ready); end
    // Asynchronous reset in the middle of the cycle with the buffer full.
    #1 reset = 1'b0;
    #1;
    q.delete();
    mb = 0;
    n_cmp += 5;
    if (up_if.ready !== 1'b0) begin n_err++; $display("FAIL mid_rst_in_ready: got %b want 0", up_if.ready); end
    if (dn_if.valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_out_valid: got %b want 0", dn_if.valid); end
    if (dn_if.ctrl !== '0) begin n_err++; $display("FAIL mid_rst_out_ctrl: got %h want 0", dn_if.ctrl); end
    if (dn_if.data !== '0) begin n_err++; $display("FAIL mid_rst_out_data: got %h want 0", dn_if.data); end
    if (occupancy !== 2'd0) begin n_err++; $display("FAIL mid_rst_occupancy: got %0d want 0", occupancy); end
    #1 reset = 1'b1;
    drive(1'b1, 12'h0A5, 69'h1, 1'b1);
    tick();
    up_if.valid = 1'b0;
    #1;
    n_cmp += 3;
    if (dn_if.valid !== 1'b1) begin n_err++; $display("FAIL first_out_valid: got %b want 1", dn_if.valid); end
    if (dn_if.ctrl !== 12'h0A5) begin n_err++; $display("FAIL first_out_ctrl: got %h want 0a5", dn_if.ctrl); end
    if (dn_if.data !== 69'h1) begin n_err++; $display("FAIL first_out_data: got %h want 1", dn_if.data); end
    tick();
  endtask

  task automatic test_streaming();
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, CTRL_W'(i), DATA_W'(i), 1'b1);
      #1;
      n_cmp++;
      if (up_if.ready !== 1'b1) begin n_err++; $display("FAIL stream_in_ready[%0d]: got %b want 1", i, up_if.ready); end
      tick();
      n_cmp += 3;
      if (dn_if.valid !== 1'b1) begin n_err++; $display("FAIL stream_valid[%0d]: got %b want 1", i, dn_if.valid); end
      if (dn_if.data !== DATA_W'(i)) begin n_err++; $display("FAIL stream_data[%0d]: got %h want %h", i, dn_if.data, i); end
      if (occupancy !== 2'd1) begin n_err++; $display("FAIL stream_occ[%0d]: got %0d want 1", i, occupancy); end
    end
    up_if.valid = 1'b0;
    tick();
    n_cmp++;
    if (occupancy !== 2'd0) begin n_err++; $display("FAIL stream_drain: got %0d want 0", occupancy); end
  endtask

  task automatic test_skid();
    drive(1'b1, 12'h010, 69'h10, 1'b0);
    tick();
    drive(1'b1, 12'h011, 69'h11, 1'b0);
    tick();
    drive(1'b1, 12'h012, 69'h12, 1'b0);
    #1;
    n_cmp += 2;
    if (occupancy !== 2'd2) begin n_err++; $display("FAIL skid_occ: got %0d want 2", occupancy); end
    if (up_if.ready !== 1'b0) begin n_err++; $display("FAIL skid_in_ready: got %b want 0", up_if.ready); end
    tick();
    dn_if.ready = 1'b1;
    #1;
    n_cmp += 2;
    if (dn_if.data !== 69'h10) begin n_err++; $display("FAIL skid_head0: got %h want 10", dn_if.data); end
    if (up_if.ready !== 1'b0) begin n_err++; $display("FAIL skid_still_full: got %b want 0", up_if.ready); end
    tick();
    #1;
    n_cmp += 2;
    if (dn_if.data !== 69'h11) begin n_err++; $display("FAIL skid_head1: got %h want 11", dn_if.data); end
    if (up_if.ready !== 1'b1) begin n_err++; $display("FAIL skid_ready_back: got %b want 1", up_if.ready); end
    tick();
    up_if.valid = 1'b0;
    #1;
    n_cmp += 2;
    if (dn_if.data !== 69'h12) begin n_err++; $display("FAIL skid_head2: got %h want 12", dn_if.data); end
    if (dn_if.ctrl !== 12'h012) begin n_err++; $display("FAIL skid_ctrl2: got %h want 012", dn_if.ctrl); end
    tick();
  endtask

  task automatic test_hold_bubble();
    int b0;
    drive(1'b1, 12'h033, 69'h33, 1'b0);
    tick();
    up_if.valid = 1'b0;
    b0 = mb;
    stall = 6'b001000;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp += 4;
      if (dn_if.valid !== 1'b0) begin n_err++; $display("FAIL hold_valid[%0d]: got %b want 0", i, dn_if.valid); end
      if (dn_if.ctrl !== '0) begin n_err++; $display("FAIL hold_ctrl[%0d]: got %h want 0", i, dn_if.ctrl); end
      if (dn_if.data !== '0) begin n_err++; $display("FAIL hold_data[%0d]: got %h want 0", i, dn_if.data); end
      if (up_if.ready !== 1'b0) begin n_err++; $display("FAIL hold_in_ready[%0d]: got %b want 0", i, up_if.ready); end
      tick();
    end
    stall = '0;
    #1;
    n_cmp += 4;
    if (bubble_cnt !== CNT_W'(b0 + 3)) begin n_err++; $display("FAIL hold_bubble: got %0d want %0d", bubble_cnt, b0 + 3); end
    if (dn_if.valid !== 1'b1) begin n_err++; $display("FAIL hold_resume_valid: got %b want 1", dn_if.valid); end
    if (dn_if.data !== 69'h33) begin n_err++; $display("FAIL hold_resume_data: got %h want 33", dn_if.data); end
    if (occupancy !== 2'd1) begin n_err++; $display("FAIL hold_occ: got %0d want 1", occupancy); end
    dn_if.ready = 1'b1;
    tick();
  endtask

  task automatic test_flush();
    int b0;
    drive(1'b1, 12'h041, 69'h41, 1'b0);
    tick();
    drive(1'b1, 12'h042, 69'h42, 1'b0);
    tick();
    drive(1'b1, 12'h044, 69'h44, 1'b0);
    flush = 1'b1;
    #1;
    n_cmp += 2;
    if (up_if.ready !== 1'b0) begin n_err++; $display("FAIL flush_in_ready: got %b want 0", up_if.ready); end
    if (dn_if.valid !== 1'b0) begin n_err++; $display("FAIL flush_out_valid: got %b want 0", dn_if.valid); end
    tick();
    flush = 1'b0;
    up_if.valid = 1'b0;
    #1;
    n_cmp += 2;
    if (occupancy !== 2'd0) begin n_err++; $display("FAIL flush_occ: got %0d want 0", occupancy); end
    if (dn_if.valid !== 1'b0) begin n_err++; $display("FAIL flush_after_valid: got %b want 0", dn_if.valid); end
    // Flush together with hold: the bubble counter must not move.
    b0 = mb;
    flush = 1'b1;
    stall = 6'b001000;
    tick();
    flush = 1'b0;
    stall = '0;
    #1;
    n_cmp++;
    if (bubble_cnt !== CNT_W'(b0)) begin n_err++; $display("FAIL flush_hold_bubble: got %0d want %0d", bubble_cnt, b0); end
  endtask

  task automatic test_saturation();
    stall2 = 6'b001000;
    for (int n = 1; n <= 20; n++) begin
      tick();
      n_cmp++;
      if (bubble_cnt2 !== 4'((n > 15) ? 15 : n)) begin
        n_err++;
        $display("FAIL sat_bubble[%0d]: got %0d want %0d", n, bubble_cnt2, (n > 15) ? 15 : n);
      end
    end
    stall2 = '0;
  endtask

  task automatic test_random();
    logic [STALL_W-1:0] s;
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 9) < 7), CTRL_W'($urandom()),
            DATA_W'({$urandom(), $urandom(), $urandom()}),
            1'($urandom_range(0, 9) < 6));
      s = STALL_W'($urandom());
      s[STAGE] = ($urandom_range(0, 5) == 0);
      stall = s;
      flush = ($urandom_range(0, 15) == 0);
      #1;
      n_cmp += 4;
      if (up_if.ready !== m_in_ready()) begin n_err++; $display("FAIL rnd_in_ready[%0d]: got %b want %b", i, up_if.ready, m_in_ready()); end
      if (dn_if.valid !== m_out_valid()) begin n_err++; $display("FAIL rnd_out_valid[%0d]: got %b want %b", i, dn_if.valid, m_out_valid()); end
      if (dn_if.ctrl !== m_ctrl()) begin n_err++; $display("FAIL rnd_out_ctrl[%0d]: got %h want %h", i, dn_if.ctrl, m_ctrl()); end
      if (dn_if.data !== m_data()) begin n_err++; $display("FAIL rnd_out_data[%0d]: got %h want %h", i, dn_if.data, m_data()); end
      tick();
      n_cmp += 2;
      if (occupancy !== 2'(q.size())) begin n_err++; $display("FAIL rnd_occ[%0d]: got %0d want %0d", i, occupancy, q.size()); end
      if (bubble_cnt !== CNT_W'(mb)) begin n_err++; $display("FAIL rnd_bubble[%0d]: got %0d want %0d", i, bubble_cnt, mb); end
    end
    stall = '0;
    flush = 1'b0;
  endtask

  initial begin
    reset  = 1'b0;
    stall  = '0;
    flush  = 1'b0;
    stall2 = '0;
    flush2 = 1'b0;
    up2_if.valid = 1'b0;
    up2_if.ctrl  = '0;
    up2_if.data  = '0;
    dn2_if.ready = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_streaming();
    test_skid();
    test_hold_bubble();
    test_flush();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
